// File: rtl/isp_dram_ctrl.sv
// Picture-level DRAM sequencer for the ISP core: one AXI4 burst per command,
// data beats passed straight through between the AXI channels and the datapath.
module isp_dram_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int unsigned PIC_BYTES = 3072,
  parameter int unsigned BEATS     = 192
) (
  input  logic         clk,
  input  logic         rst,

  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_wr,
  input  logic [3:0]   cmd_pic_no,

  output logic [127:0] rd_data,
  output logic         rd_valid,
  input  logic         rd_ready,
  input  logic [127:0] wr_data,
  input  logic         wr_valid,
  output logic         wr_ready,
  output logic         done,
  output logic         err,

  output logic [31:0]  araddr_s_inf,
  output logic [7:0]   arlen_s_inf,
  output logic         arvalid_s_inf,
  input  logic         arready_s_inf,
  input  logic [127:0] rdata_s_inf,
  input  logic [1:0]   rresp_s_inf,
  input  logic         rlast_s_inf,
  input  logic         rvalid_s_inf,
  output logic         rready_s_inf,

  output logic [31:0]  awaddr_s_inf,
  output logic [7:0]   awlen_s_inf,
  output logic         awvalid_s_inf,
  input  logic         awready_s_inf,
  output logic [127:0] wdata_s_inf,
  output logic         wlast_s_inf,
  output logic         wvalid_s_inf,
  input  logic         wready_s_inf,
  input  logic [1:0]   bresp_s_inf,
  input  logic         bvalid_s_inf,
  output logic         bready_s_inf
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_AW   = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_BRSP = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  localparam logic [7:0] LAST_BEAT = 8'(BEATS - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic        err_q, err_d;
  logic [31:0] araddr_q, araddr_d;
  logic [31:0] awaddr_q, awaddr_d;

  logic        cmd_fire, r_fire, w_fire, is_last;
  logic [31:0] pic_addr;

  // Control outputs are decodes of the state register; data paths are pass-through.
  assign cmd_ready     = (state_q == S_IDLE);
  assign arvalid_s_inf = (state_q == S_AR);
  assign awvalid_s_inf = (state_q == S_AW);
  assign bready_s_inf  = (state_q == S_BRSP);
  assign done          = (state_q == S_DONE);
  assign err           = err_q;

  assign araddr_s_inf  = araddr_q;
  assign awaddr_s_inf  = awaddr_q;
  assign arlen_s_inf   = LAST_BEAT;
  assign awlen_s_inf   = LAST_BEAT;

  assign rd_data       = rdata_s_inf;
  assign rd_valid      = (state_q == S_RD) & rvalid_s_inf;
  assign rready_s_inf  = (state_q == S_RD) & rd_ready;

  assign wdata_s_inf   = wr_data;
  assign wvalid_s_inf  = (state_q == S_WR) & wr_valid;
  assign wr_ready      = (state_q == S_WR) & wready_s_inf;

  assign is_last       = (count_q == LAST_BEAT);
  assign wlast_s_inf   = (state_q == S_WR) & is_last;

  assign cmd_fire = cmd_valid & cmd_ready;
  assign r_fire   = rvalid_s_inf & rready_s_inf;
  assign w_fire   = wvalid_s_inf & wready_s_inf;
  assign pic_addr = BASE_ADDR + 32'(cmd_pic_no) * 32'(PIC_BYTES);

  // Next-state and datapath-register update
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    err_d    = err_q;
    araddr_d = araddr_q;
    awaddr_d = awaddr_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          count_d = 8'd0;
          err_d   = 1'b0;
          if (cmd_wr) begin
            awaddr_d = pic_addr;
            state_d  = S_AW;
          end else begin
            araddr_d = pic_addr;
            state_d  = S_AR;
          end
        end
      end
      S_AR: begin
        if (arready_s_inf) state_d = S_RD;
      end
      S_RD: begin
        if (r_fire) begin
          count_d = count_q + 8'd1;
          // rlast must coincide exactly with the final beat of the burst
          if ((rlast_s_inf != is_last) || (rresp_s_inf != 2'b00)) err_d = 1'b1;
          if (is_last) state_d = S_DONE;
        end
      end
      S_AW: begin
        if (awready_s_inf) state_d = S_WR;
      end
      S_WR: begin
        if (w_fire) begin
          count_d = count_q + 8'd1;
          if (is_last) state_d = S_BRSP;
        end
      end
      S_BRSP: begin
        if (bvalid_s_inf) begin
          if (bresp_s_inf != 2'b00) err_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= 8'd0;
      err_q    <= 1'b0;
      araddr_q <= 32'd0;
      awaddr_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      err_q    <= err_d;
      araddr_q <= araddr_d;
      awaddr_q <= awaddr_d;
    end
  end

endmodule
